// File: rtl/imem_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory port arbiter.
package imem_arbiter_pkg;

  localparam int unsigned WORD           = 32;
  localparam int unsigned ADDR           = 16;
  localparam int unsigned STARVE_MAX_DEF = 4;

  // Owner of the read response returning on the next cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_LS = 2'd2
  } owner_e;

  // Request presented to the memory port by the winning requester.
  typedef struct packed {
    logic [ADDR-1:0] addr;
    logic            we;
    logic [WORD-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/imem_arb_starve_cnt.sv
// Saturating fetch-starvation counter with synchronous clear.
module imem_arb_starve_cnt #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt_o
);

  // Count denied fetch cycles, holding at MAX; clear has priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_o <= '0;
    end else if (clr) begin
      cnt_o <= '0;
    end else if (inc && (cnt_o != W'(MAX))) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Arbiter for the single synchronous memory port shared by fetch and load/store.
// Load/store has priority; a starvation counter forces a fetch grant.
// Optional performance counters are enabled with IMEM_ARBITER_PERF_EN.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req_i,
  input  logic [ADDR-1:0] if_addr_i,
  input  logic            if_flush_i,
  output logic            if_gnt_o,
  output logic            if_v_o,
  output logic [WORD-1:0] if_data_o,
  input  logic            ls_req_i,
  input  logic            ls_we_i,
  input  logic [ADDR-1:0] ls_addr_i,
  input  logic [WORD-1:0] ls_wdata_i,
  output logic            ls_gnt_o,
  output logic            ls_v_o,
  output logic [WORD-1:0] ls_data_o,
  output logic [ADDR-1:0] mem_a_o,
  output logic            mem_w_o,
  output logic [WORD-1:0] mem_d_o,
  input  logic [WORD-1:0] mem_q_i
`ifdef IMEM_ARBITER_PERF_EN
  ,
  output logic [31:0]     perf_conflict_o,
  output logic [31:0]     perf_starve_o
`endif
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          force_if_c;
  logic          starve_inc;
  logic          starve_clr;
  mem_req_t      mem_req;
  owner_e        owner_q;
  owner_e        owner_d;
  logic          flush_q;

  assign force_if_c = if_req_i && (starve_cnt == CW'(STARVE_MAX));

  // Same-cycle grant: load/store wins unless fetch has starved; nothing while in reset.
  always_comb begin
    ls_gnt_o = 1'b0;
    if_gnt_o = 1'b0;
    if (reset) begin
      if (ls_req_i && !force_if_c) begin
        ls_gnt_o = 1'b1;
      end else if (if_req_i) begin
        if_gnt_o = 1'b1;
      end
    end
  end

  // Winner's request onto the memory port; idle port drives zeros.
  always_comb begin
    mem_req = '0;
    if (ls_gnt_o) begin
      mem_req.addr  = ls_addr_i;
      mem_req.we    = ls_we_i;
      mem_req.wdata = ls_wdata_i;
    end else if (if_gnt_o) begin
      mem_req.addr  = if_addr_i;
    end
  end

  assign mem_a_o = mem_req.addr;
  assign mem_w_o = mem_req.we;
  assign mem_d_o = mem_req.wdata;

  assign starve_inc = if_req_i && !if_gnt_o;
  assign starve_clr = if_gnt_o || !if_req_i;

  imem_arb_starve_cnt #(
    .MAX (STARVE_MAX),
    .W   (CW)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .cnt_o (starve_cnt)
  );

  // Response owner and fetch-flush capture for the next cycle's read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= IDLE;
      flush_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      flush_q <= if_flush_i;
    end
  end

  // Next owner: stores return nothing, so they leave the port idle.
  always_comb begin
    owner_d = IDLE;
    if (if_gnt_o) begin
      owner_d = RESP_IF;
    end else if (ls_gnt_o && !ls_we_i) begin
      owner_d = RESP_LS;
    end
  end

  assign if_v_o    = (owner_q == RESP_IF) && !flush_q;
  assign ls_v_o    = (owner_q == RESP_LS);
  assign if_data_o = if_v_o ? mem_q_i : '0;
  assign ls_data_o = ls_v_o ? mem_q_i : '0;

`ifdef IMEM_ARBITER_PERF_EN
  // Conflict cycles and grants won only through the starvation override.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_conflict_o <= '0;
      perf_starve_o   <= '0;
    end else begin
      if (if_req_i && ls_req_i) begin
        perf_conflict_o <= perf_conflict_o + 32'd1;
      end
      if (force_if_c && ls_req_i) begin
        perf_starve_o <= perf_starve_o + 32'd1;
      end
    end
  end
`endif

endmodule
